hilo_muldiv_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer plus owner of the HI/LO register pair.
- Sits beside the EX stage. Accepts MULT/MULTU/DIV/DIVU from EX and stalls the pipeline until the result is ready.
- Writes the 64-bit result into HI/LO.
- Arbitrates that write against MTHI/MTLO writes arriving from WB.

---
 rtl/hilo_muldiv_ctrl_pkg.sv | 24 ++
 rtl/hilo_muldiv_ctrl_div_step.sv | 25 ++
 rtl/hilo_muldiv_ctrl.sv | 144 ++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the HI/LO multiply/divide sequencer.
// The HILO_FWD_EN macro (see hilo_muldiv_ctrl.sv) does not affect this package.
package hilo_muldiv_ctrl_pkg;

  localparam int unsigned HILO_W = 32;
  localparam int unsigned CNT_W  = 6;

  localparam logic [1:0] MD_DIV   = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_MULTU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_RUN,
    S_MUL_RUN,
    S_DONE
  } md_state_e;

  function automatic logic [HILO_W-1:0] neg_if(input logic [HILO_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One restoring-division iteration on a {rem, quo} shift register.
// The HILO_FWD_EN macro (see hilo_muldiv_ctrl.sv) does not affect this module.
module hilo_muldiv_ctrl_div_step
  import hilo_muldiv_ctrl_pkg::*;
(
  input  logic [2*HILO_W-1:0] i_acc,
  input  logic [HILO_W-1:0]   i_divisor,
  output logic [2*HILO_W-1:0] o_acc
);

  logic [HILO_W:0] w_trial;
  logic [HILO_W:0] w_diff;

  // 33-bit trial keeps the bit shifted out of rem so divisors >= 2^31 work.
  assign w_trial = i_acc[2*HILO_W-1:HILO_W-1];
  assign w_diff  = w_trial - {1'b0, i_divisor};

  always_comb begin
    o_acc = {w_trial[HILO_W-1:0], i_acc[HILO_W-2:0], 1'b0};
    if (!w_diff[HILO_W]) begin
      o_acc = {w_diff[HILO_W-1:0], i_acc[HILO_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, arbitrating against MTHI/MTLO.
// Define HILO_FWD_EN to forward the value being written this cycle onto hi_o/lo_o.
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  input  logic [1:0]        op_code_i,
  input  logic [HILO_W-1:0] src_a_i,
  input  logic [HILO_W-1:0] src_b_i,
  input  logic              flush_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [HILO_W-1:0] hilo_wdata_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              div_zero_o,
  output logic [HILO_W-1:0] hi_o,
  output logic [HILO_W-1:0] lo_o
);

  md_state_e r_state, w_next;

  logic [CNT_W-1:0]    r_cnt;
  logic                r_is_div, r_sign_q, r_sign_r;
  logic [HILO_W-1:0]   r_mag_a, r_mag_b, r_hi, r_lo;
  logic [2*HILO_W-1:0] r_acc, w_step, w_prod_mag, w_prod;

  logic                w_accept, w_op_div, w_op_signed, w_done_we, w_bz;
  logic                w_hi_we, w_lo_we;
  logic [HILO_W-1:0]   w_mag_a, w_mag_b, w_res_hi, w_res_lo, w_hi_d, w_lo_d;

  assign w_op_div    = (op_code_i == MD_DIV)  || (op_code_i == MD_DIVU);
  assign w_op_signed = (op_code_i == MD_DIV)  || (op_code_i == MD_MULT);
  assign w_mag_a     = neg_if(src_a_i, w_op_signed & src_a_i[HILO_W-1]);
  assign w_mag_b     = neg_if(src_b_i, w_op_signed & src_b_i[HILO_W-1]);
  assign w_accept    = (r_state == S_IDLE) & op_valid_i & ~flush_i;

  hilo_muldiv_ctrl_div_step u_div_step (
    .i_acc     (r_acc),
    .i_divisor (r_mag_b),
    .o_acc     (w_step)
  );

  // Multiply on magnitudes, then apply the sign: one multiplier serves MULT and MULTU.
  assign w_prod_mag = {{HILO_W{1'b0}}, r_mag_a} * {{HILO_W{1'b0}}, r_mag_b};
  assign w_prod     = r_sign_q ? -w_prod_mag : w_prod_mag;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (op_valid_i) w_next = op_code_i[1] ? S_MUL_RUN : S_DIV_RUN;
        S_DIV_RUN: if (r_cnt == CNT_W'(DIV_ITER - 1)) w_next = S_DONE;
        S_MUL_RUN: if (r_cnt == CNT_W'(MUL_LAT - 1))  w_next = S_DONE;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o    = 1'b0;
    div_zero_o = 1'b0;
    w_done_we  = 1'b0;
    busy_o     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:                stall_o = w_accept;
      S_DIV_RUN, S_MUL_RUN:  stall_o = ~flush_i;
      S_DONE: begin
        w_done_we  = ~flush_i;
        div_zero_o = ~flush_i & r_is_div & w_bz;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= w_op_div;
      r_sign_q <= w_op_signed & (src_a_i[HILO_W-1] ^ src_b_i[HILO_W-1]);
      r_sign_r <= w_op_signed & src_a_i[HILO_W-1];
      r_mag_a  <= w_mag_a;
      r_mag_b  <= w_mag_b;
      r_acc    <= {{HILO_W{1'b0}}, w_mag_a};
    end else if (r_state == S_DIV_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_step;
    end else if (r_state == S_MUL_RUN) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_prod;
    end
  end

  // Divide by zero: the restoring loop leaves rem=|a|, so the HI fixup restores src_a.
  assign w_bz     = (r_mag_b == '0);
  assign w_res_hi = r_is_div ? neg_if(r_acc[2*HILO_W-1:HILO_W], r_sign_r) : r_acc[2*HILO_W-1:HILO_W];
  assign w_res_lo = !r_is_div ? r_acc[HILO_W-1:0] :
                    w_bz      ? '1 : neg_if(r_acc[HILO_W-1:0], r_sign_q);

  assign w_hi_we = w_done_we | hi_we_i;
  assign w_lo_we = w_done_we | lo_we_i;
  assign w_hi_d  = w_done_we ? w_res_hi : hilo_wdata_i;
  assign w_lo_d  = w_done_we ? w_res_lo : hilo_wdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
    end
  end

`ifdef HILO_FWD_EN
  assign hi_o = w_hi_we ? w_hi_d : r_hi;
  assign lo_o = w_lo_we ? w_lo_d : r_lo;
`else
  assign hi_o = r_hi;
  assign lo_o = r_lo;
`endif

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl; expectations come from plain integer arithmetic.
// Honours HILO_FWD_EN to pick same-cycle or next-cycle HI/LO visibility.
module tb_hilo_muldiv_ctrl;
  import hilo_muldiv_ctrl_pkg::*;

  localparam int MUL_LAT  = 2;
  localparam int DIV_ITER = 32;
`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, op_valid_i, flush_i, hi_we_i, lo_we_i;
  logic [1:0]  op_code_i;
  logic [31:0] src_a_i, src_b_i, hilo_wdata_i;
  logic        stall_o, busy_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid_i   (op_valid_i),
    .op_code_i    (op_code_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .flush_i      (flush_i),
    .hi_we_i      (hi_we_i),
    .lo_we_i      (lo_we_i),
    .hilo_wdata_i (hilo_wdata_i),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .div_zero_o   (div_zero_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_DIVU: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      MD_DIV: begin
        if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
      end
      MD_MULT: begin
        p = sa * sb; hi = p[63:32]; lo = p[31:0];
      end
      default: begin
        p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 1000));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit wb_in_done, input string name);
    int n, exp_n;
    logic exp_dz;
    logic [31:0] old_hi, old_lo, now_hi, now_lo;
    exp_n  = op[1] ? MUL_LAT + 1 : DIV_ITER + 1;
    exp_dz = !op[1] && (b == 0);
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge clk);
    op_valid_i = 1'b1; op_code_i = op; src_a_i = a; src_b_i = b;
    #1;
    n = 0;
    while (stall_o === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      src_a_i = $urandom; src_b_i = $urandom;
      #1;
    end
    checks++;
    if (n !== exp_n) begin
      errors++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, n, exp_n);
    end
    if (wb_in_done) begin
      hi_we_i = 1'b1; lo_we_i = 1'b1; hilo_wdata_i = 32'h0000_AAAA;
      #1;
    end
    now_hi = FWD ? exp_hi : old_hi;
    now_lo = FWD ? exp_lo : old_lo;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL %s busy_in_done: got %b expected 1", name, busy_o);
    end
    checks++;
    if (div_zero_o !== exp_dz) begin
      errors++; $display("FAIL %s div_zero_in_done: got %b expected %b", name, div_zero_o, exp_dz);
    end
    checks++;
    if (hi_o !== now_hi || lo_o !== now_lo) begin
      errors++; $display("FAIL %s hilo_in_done: got %h/%h expected %h/%h", name, hi_o, lo_o, now_hi, now_lo);
    end
    @(negedge clk);
    op_valid_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || div_zero_o !== 1'b0) begin
      errors++; $display("FAIL %s idle_after_done: got busy=%b stall=%b dz=%b expected 0/0/0",
                         name, busy_o, stall_o, div_zero_o);
    end
    checks++;
    if (hi_o !== exp_hi || lo_o !== exp_lo) begin
      errors++; $display("FAIL %s hilo_after: got %h/%h expected %h/%h", name, hi_o, lo_o, exp_hi, exp_lo);
    end
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_valid_i = 1'b0; op_code_i = 2'b00; src_a_i = '0; src_b_i = '0;
    flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0; hilo_wdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || div_zero_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%b stall=%b dz=%b hi=%h lo=%h expected all 0",
                         busy_o, stall_o, div_zero_o, hi_o, lo_o);
    end
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] e_hi, e_lo;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      hi_we_i = 1'($urandom_range(0, 1));
      lo_we_i = 1'($urandom_range(0, 1));
      hilo_wdata_i = $urandom;
      #1;
      e_hi = (FWD && hi_we_i) ? hilo_wdata_i : m_hi;
      e_lo = (FWD && lo_we_i) ? hilo_wdata_i : m_lo;
      checks++;
      if (hi_o !== e_hi || lo_o !== e_lo) begin
        errors++; $display("FAIL wb_write[%0d]: got %h/%h expected %h/%h", i, hi_o, lo_o, e_hi, e_lo);
      end
      if (hi_we_i) m_hi = hilo_wdata_i;
      if (lo_we_i) m_lo = hilo_wdata_i;
    end
    @(negedge clk);
    hi_we_i = 1'b1; lo_we_i = 1'b0; hilo_wdata_i = 32'h55;
    #1;
    e_hi = FWD ? 32'h55 : m_hi;
    checks++;
    if (hi_o !== e_hi) begin
      errors++; $display("FAIL mthi_55_same_cycle: got %h expected %h", hi_o, e_hi);
    end
    m_hi = 32'h55;
    @(negedge clk);
    hi_we_i = 1'b0;
    #1;
    checks++;
    if (hi_o !== 32'h55 || lo_o !== m_lo) begin
      errors++; $display("FAIL mthi_55_next_cycle: got %h/%h expected %h/%h", hi_o, lo_o, 32'h55, m_lo);
    end
  endtask

  task automatic test_directed();
    run_op(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, "divu_100_7");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, "div_min_m1");
    run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_m2_3");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(MD_DIVU,  32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, 1'b0, "divu_by_zero");
    run_op(MD_DIV,   32'hFFFF_0000, 32'h0,         32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, "div_neg_by_zero");
  endtask

  task automatic test_wb_priority();
    run_op(MD_DIV, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b1, "done_vs_wb");
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, e_hi, e_lo;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_val();
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : pick_val();
      model_op(op, a, b, e_hi, e_lo);
      run_op(op, a, b, e_hi, e_lo, 1'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, op));
    end
  endtask

  task automatic test_flush();
    int n;
    @(negedge clk);
    op_valid_i = 1'b1; op_code_i = MD_DIV; src_a_i = $urandom; src_b_i = $urandom | 32'h1;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL flush_accept_stall: got %b expected 1", stall_o);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) flush_i = 1'b1;
      #1;
    end
    checks++;
    if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_t10: got stall=%b busy=%b expected 0/1", stall_o, busy_o);
    end
    @(negedge clk);
    flush_i = 1'b0; op_valid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo) begin
      errors++; $display("FAIL flush_t11: got busy=%b stall=%b hilo=%h/%h expected 0/0 %h/%h",
                         busy_o, stall_o, hi_o, lo_o, m_hi, m_lo);
    end
    // Flush in DONE on a divide-by-zero: no pulse, no write.
    @(negedge clk);
    op_valid_i = 1'b1; op_code_i = MD_DIVU; src_a_i = 32'hBEEF; src_b_i = 32'h0;
    #1;
    n = 0;
    while (stall_o === 1'b1 && n < 200) begin
      n++; @(negedge clk); #1;
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (n !== DIV_ITER + 1 || div_zero_o !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo) begin
      errors++; $display("FAIL flush_done: got n=%0d dz=%b hilo=%h/%h expected %0d 0 %h/%h",
                         n, div_zero_o, hi_o, lo_o, DIV_ITER + 1, m_hi, m_lo);
    end
    @(negedge clk);
    flush_i = 1'b0; op_valid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || hi_o !== m_hi || lo_o !== m_lo) begin
      errors++; $display("FAIL flush_done_after: got busy=%b hilo=%h/%h expected 0 %h/%h",
                         busy_o, hi_o, lo_o, m_hi, m_lo);
    end
    @(negedge clk);
    op_valid_i = 1'b1; op_code_i = MD_MULT; flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL flush_at_accept_stall: got %b expected 0", stall_o);
    end
    @(negedge clk);
    op_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL flush_at_accept_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    op_valid_i = 1'b1; op_code_i = MD_DIVU; src_a_i = 32'd999; src_b_i = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1; op_valid_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || stall_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
      errors++; $display("FAIL reset_midop: got busy=%b stall=%b hilo=%h/%h expected 0/0 0/0",
                         busy_o, stall_o, hi_o, lo_o);
    end
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
      errors++; $display("FAIL reset_midop_settle: got busy=%b hilo=%h/%h expected 0 0/0", busy_o, hi_o, lo_o);
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_directed();
    test_wb_priority();
    test_flush();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
